flag_register_unit: RTL and testbench
=====================================

// Module: flag_register_unit
// PURPOSE
//  Architectural NZCV flag register and flag writer for the execute stage.
//  - Captures ALU flags from conditionally executed, flag-setting instructions.
//  - Commits them one cycle later.
//  - Drives flags_o ({C,N,V,Z}) to the condition evaluator.
//  - Gates side effects with the evaluator's returned cond_ex_i.
//  - Provides a one-entry shadow (save/restore) for exception entry/return.
// PARAMETERS
//  RESET_FLAGS  4'b0000  value of arch and shadow flags after reset, ordered {C,N,V,Z}
//  SHADOW_EN    1        1: shadow register and save_i/restore_i active; 0: inputs ignored, shadow_o=0
// PORTS
//  clk          in   1  single clock, all state updates on rising edge
//  reset        in   1  synchronous, active-high reset
//  valid_i      in   1  an instruction is present in execute this cycle
//  cond_ex_i    in   1  condition passed, returned by the evaluator for flags_o
//  flag_write_i in   2  [1]: update N,Z; [0]: update C,V
//  alu_flags_i  in   4  ALU result flags {C,N,V,Z}
//  reg_write_i  in   1  raw register write request
//  mem_write_i  in   1  raw memory write request
//  pc_src_i     in   1  raw branch/PC write request
//  stall_i      in   1  execute stage held; no new capture
//  flush_i      in   1  squash the pending update and the current capture
//  save_i       in   1  copy effective flags to the shadow register
//  restore_i    in   1  load arch flags from the shadow register
//  flags_o      out  4  flags presented to the evaluator {C,N,V,Z}
//  shadow_o     out  4  shadow register contents
//  flag_hazard_o out 1  flags_o is stale; the issuer must stall
//  reg_write_o  out  1  gated register write
//  mem_write_o  out  1  gated memory write
//  pc_src_o     out  1  gated PC write
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - arch = shadow = RESET_FLAGS; pend_valid = 0.
//   - Outputs settle to: flags_o=RESET_FLAGS, flag_hazard_o=0, gated outputs follow their comb terms.
//  Gating (combinational):
//   - x_o = valid_i & cond_ex_i & x_i & ~flush_i, for x in {reg_write, mem_write, pc_src}.
//  Capture stage (registered):
//   - Condition: ~stall_i & ~flush_i & ~restore_i.
//   - pend_valid <= valid_i & cond_ex_i & |flag_write_i.
//   - pend_we <= flag_write_i; pend_flags <= alu_flags_i.
//   - If the condition is false: pend_valid <= 0 once the current pending entry has committed.
//  Commit stage (same edge, uses the old pend_*):
//   - If pend_valid & ~flush_i & ~restore_i: arch.N,Z <= pend.N,Z when pend_we[1]; arch.C,V <= pend.C,V when pend_we[0].
//   - Commit latency: 2 edges from capture cycle to arch update; each entry commits exactly once, stall or not.
//  Effective flags (eff):
//   - eff = arch with pend fields merged per pend_we when pend_valid, else arch.
//  Save / restore:
//   - save_i: shadow <= eff, so a pending update is included.
//   - restore_i: arch <= shadow and pend_valid <= 0; overrides both commit and capture that edge.
//   - save_i & restore_i together: restore wins, shadow unchanged.
//  flush_i: drops the pending entry without committing; arch unchanged.
//  reset mid-operation: pending entry discarded, no commit.
// CONFIGURATION
//  FLAG_BYPASS_EN defined:
//   - flags_o = eff, so a back-to-back dependent condition sees the new flags.
//   - flag_hazard_o = 0 constant.
//  FLAG_BYPASS_EN undefined:
//   - flags_o = arch.
//   - flag_hazard_o = pend_valid: the issuer must stall one cycle before an instruction that reads flags.
// TESTING
//  1 reset=1 one edge -> flags_o=4'b0000, pend_valid=0, flag_hazard_o=0.
//  2 valid,cond_ex=1,flag_write=2'b11,alu=4'b1010 -> with bypass flags_o=1010 next cycle;
//    without bypass flag_hazard_o=1 next cycle and flags_o=1010 one cycle later.
//  3 arch=1111, flag_write=2'b10, alu=4'b0000 -> arch=1010 (C,V kept; N,Z cleared).
//  4 cond_ex=0 with flag_write=11, reg/mem/pc_src=1 -> arch unchanged; all gated outputs 0.
//  5 capture alu=0101, then flush_i on the next edge -> arch stays 0000; pending entry dropped.
//  6 arch=1000, save_i; later arch=0001, restore_i together with a commit of 0110 -> arch=1000, commit dropped.

Source files
------------

// File: rtl/flag_register_unit.sv
// NZCV flag register with one-cycle deferred commit, side-effect gating and a save/restore shadow.
// Optional FLAG_BYPASS_EN: present effective (pending-merged) flags and drop the hazard output.
module flag_register_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         SHADOW_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic       cond_ex_i,
  input  logic [1:0] flag_write_i,
  input  logic [3:0] alu_flags_i,
  input  logic       reg_write_i,
  input  logic       mem_write_i,
  input  logic       pc_src_i,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic       save_i,
  input  logic       restore_i,
  output logic [3:0] flags_o,
  output logic [3:0] shadow_o,
  output logic       flag_hazard_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_src_o
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FW_W   = 2;
  // Bit positions within the {C,N,V,Z} vector
  localparam int unsigned C_B = 3;
  localparam int unsigned N_B = 2;
  localparam int unsigned V_B = 1;
  localparam int unsigned Z_B = 0;

  logic [FLAG_W-1:0] arch_q, arch_d;
  logic [FLAG_W-1:0] shadow_q, shadow_d;
  logic              pend_valid_q, pend_valid_d;
  logic [FW_W-1:0]   pend_we_q, pend_we_d;
  logic [FLAG_W-1:0] pend_flags_q, pend_flags_d;

  logic [FLAG_W-1:0] eff_c;
  logic              restore_en_c;
  logic              save_en_c;
  logic              capture_c;
  logic              issue_ok_c;

  // Effective flags: architectural state with the pending entry merged in
  always_comb begin
    eff_c = arch_q;
    if (pend_valid_q) begin
      if (pend_we_q[1]) begin
        eff_c[N_B] = pend_flags_q[N_B];
        eff_c[Z_B] = pend_flags_q[Z_B];
      end
      if (pend_we_q[0]) begin
        eff_c[C_B] = pend_flags_q[C_B];
        eff_c[V_B] = pend_flags_q[V_B];
      end
    end
  end

  // Next-state for arch, shadow and the pending entry
  always_comb begin
    restore_en_c = SHADOW_EN & restore_i;
    save_en_c    = SHADOW_EN & save_i;
    capture_c    = ~stall_i & ~flush_i & ~restore_en_c;

    arch_d       = arch_q;
    shadow_d     = shadow_q;
    pend_valid_d = 1'b0;
    pend_we_d    = pend_we_q;
    pend_flags_d = pend_flags_q;

    if (restore_en_c) begin
      arch_d = shadow_q;
    end else if (pend_valid_q && !flush_i) begin
      arch_d = eff_c;
    end

    if (save_en_c && !restore_en_c) begin
      shadow_d = eff_c;
    end

    // A stalled/flushed/restoring cycle leaves pend_valid cleared; any old entry committed above
    if (capture_c) begin
      pend_valid_d = valid_i & cond_ex_i & (|flag_write_i);
      pend_we_d    = flag_write_i;
      pend_flags_d = alu_flags_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arch_q       <= RESET_FLAGS;
      shadow_q     <= RESET_FLAGS;
      pend_valid_q <= 1'b0;
      pend_we_q    <= '0;
      pend_flags_q <= '0;
    end else begin
      arch_q       <= arch_d;
      shadow_q     <= shadow_d;
      pend_valid_q <= pend_valid_d;
      pend_we_q    <= pend_we_d;
      pend_flags_q <= pend_flags_d;
    end
  end

  // Side effects only for a live, condition-passing, unflushed instruction
  always_comb begin
    issue_ok_c  = valid_i & cond_ex_i & ~flush_i;
    reg_write_o = issue_ok_c & reg_write_i;
    mem_write_o = issue_ok_c & mem_write_i;
    pc_src_o    = issue_ok_c & pc_src_i;
  end

  assign shadow_o = SHADOW_EN ? shadow_q : FLAG_W'(0);

`ifdef FLAG_BYPASS_EN
  assign flags_o       = eff_c;
  assign flag_hazard_o = 1'b0;
`else
  assign flags_o       = arch_q;
  assign flag_hazard_o = pend_valid_q;
`endif

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed vector table followed by randomized traffic
// checked against a queue-based reference model of the flag pipeline.
module tb_flag_register_unit;

  logic       clk;
  logic       reset;
  logic       valid_i, cond_ex_i;
  logic [1:0] flag_write_i;
  logic [3:0] alu_flags_i;
  logic       reg_write_i, mem_write_i, pc_src_i;
  logic       stall_i, flush_i, save_i, restore_i;
  logic [3:0] flags_o, shadow_o;
  logic       flag_hazard_o, reg_write_o, mem_write_o, pc_src_o;

  int n_tests = 0;
  int n_fail  = 0;

  flag_register_unit dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .cond_ex_i(cond_ex_i),
    .flag_write_i(flag_write_i), .alu_flags_i(alu_flags_i),
    .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
    .stall_i(stall_i), .flush_i(flush_i), .save_i(save_i), .restore_i(restore_i),
    .flags_o(flags_o), .shadow_o(shadow_o), .flag_hazard_o(flag_hazard_o),
    .reg_write_o(reg_write_o), .mem_write_o(mem_write_o), .pc_src_o(pc_src_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, valid, cond;
    logic [1:0] fw;
    logic [3:0] alu;
    logic [2:0] xin;   // {reg, mem, pc}
    logic [3:0] ctl;   // {stall, flush, save, restore}
    logic       chk;
    logic [3:0] exp_arch, exp_eff;
    logic       exp_pend;
    logic [3:0] exp_shadow;
    logic [2:0] exp_gate;
  } vec_t;

  typedef struct {
    logic [1:0] we;
    logic [3:0] flags;
  } pend_t;

  vec_t  tbl[$];
  pend_t m_pend[$];
  logic [3:0] m_arch, m_shadow;

  function automatic void add(input logic rst, input logic v, input logic c, input logic [1:0] fw,
                              input logic [3:0] alu, input logic [2:0] xin, input logic [3:0] ctl,
                              input logic chk, input logic [3:0] ea, input logic [3:0] ee,
                              input logic ep, input logic [3:0] es, input logic [2:0] eg);
    vec_t r;
    r = '{rst, v, c, fw, alu, xin, ctl, chk, ea, ee, ep, es, eg};
    tbl.push_back(r);
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic c, input logic [1:0] fw,
                       input logic [3:0] alu, input logic [2:0] xin, input logic [3:0] ctl);
    reset = rst; valid_i = v; cond_ex_i = c; flag_write_i = fw; alu_flags_i = alu;
    {reg_write_i, mem_write_i, pc_src_i} = xin;
    {stall_i, flush_i, save_i, restore_i} = ctl;
  endtask

  // Compare all observable outputs against an expected architectural picture
  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] ee,
                           input logic ep, input logic [3:0] es, input logic [2:0] eg);
`ifdef FLAG_BYPASS_EN
    check({tag, " flags_o"}, flags_o, ee);
    check({tag, " hazard"}, {3'b000, flag_hazard_o}, 4'b0000);
`else
    check({tag, " flags_o"}, flags_o, ea);
    check({tag, " hazard"}, {3'b000, flag_hazard_o}, {3'b000, ep});
`endif
    check({tag, " shadow_o"}, shadow_o, es);
    check({tag, " gates"}, {1'b0, reg_write_o, mem_write_o, pc_src_o}, {1'b0, eg});
  endtask

  function automatic logic [3:0] model_eff();
    logic [3:0] mask;
    if (m_pend.size() == 0) return m_arch;
    // {C,N,V,Z}: NZ controlled by we[1], CV by we[0]
    mask = {m_pend[0].we[0], m_pend[0].we[1], m_pend[0].we[0], m_pend[0].we[1]};
    return (m_arch & ~mask) | (m_pend[0].flags & mask);
  endfunction

  function automatic void model_step();
    logic [3:0] eff, new_shadow;
    pend_t p;
    eff = model_eff();
    if (reset) begin
      m_arch = 4'b0000; m_shadow = 4'b0000; m_pend.delete();
      return;
    end
    new_shadow = (save_i && !restore_i) ? eff : m_shadow;
    if (restore_i) begin
      m_arch = m_shadow;
      m_pend.delete();
    end else begin
      if (m_pend.size() != 0 && !flush_i) m_arch = eff;
      m_pend.delete();
      if (!stall_i && !flush_i && valid_i && cond_ex_i && flag_write_i != 2'b00) begin
        p.we = flag_write_i; p.flags = alu_flags_i;
        m_pend.push_back(p);
      end
    end
    m_shadow = new_shadow;
  endfunction

  initial begin
    drive(1'b1, 0, 0, 2'b00, 4'h0, 3'b000, 4'b0000);

    add(1,0,0,2'b00,4'b0000,3'b000,4'b0000,0,4'b0000,4'b0000,0,4'b0000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b0000,4'b0000,0,4'b0000,3'b000);
    add(0,1,1,2'b11,4'b1010,3'b111,4'b0000,1,4'b0000,4'b0000,0,4'b0000,3'b111);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b0000,4'b1010,1,4'b0000,3'b000);
    add(0,1,1,2'b11,4'b1111,3'b000,4'b0000,1,4'b1010,4'b1010,0,4'b0000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b1010,4'b1111,1,4'b0000,3'b000);
    add(0,1,1,2'b10,4'b0000,3'b000,4'b0000,1,4'b1111,4'b1111,0,4'b0000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b1111,4'b1010,1,4'b0000,3'b000);
    add(0,1,0,2'b11,4'b0000,3'b111,4'b0000,1,4'b1010,4'b1010,0,4'b0000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b1010,4'b1010,0,4'b0000,3'b000);
    add(1,0,0,2'b00,4'b0000,3'b000,4'b0000,0,4'b0000,4'b0000,0,4'b0000,3'b000);
    add(0,1,1,2'b11,4'b0101,3'b100,4'b0000,1,4'b0000,4'b0000,0,4'b0000,3'b100);
    add(0,1,1,2'b11,4'b0000,3'b100,4'b0100,1,4'b0000,4'b0101,1,4'b0000,3'b000);
    add(0,1,1,2'b01,4'b1000,3'b000,4'b0000,1,4'b0000,4'b0000,0,4'b0000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b0000,4'b1000,1,4'b0000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0010,1,4'b1000,4'b1000,0,4'b0000,3'b000);
    add(0,1,1,2'b11,4'b0001,3'b000,4'b0000,1,4'b1000,4'b1000,0,4'b1000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b1000,4'b0001,1,4'b1000,3'b000);
    add(0,1,1,2'b11,4'b0110,3'b000,4'b0000,1,4'b0001,4'b0001,0,4'b1000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0001,1,4'b0001,4'b0110,1,4'b1000,3'b000);
    add(0,1,1,2'b11,4'b0011,3'b000,4'b0000,1,4'b1000,4'b1000,0,4'b1000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0011,1,4'b1000,4'b0011,1,4'b1000,3'b000);
    add(0,1,1,2'b11,4'b0100,3'b000,4'b0000,1,4'b1000,4'b1000,0,4'b1000,3'b000);
    add(0,1,1,2'b11,4'b1111,3'b001,4'b1000,1,4'b1000,4'b0100,1,4'b1000,3'b001);
    add(0,1,1,2'b11,4'b0010,3'b000,4'b0000,1,4'b0100,4'b0100,0,4'b1000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0010,1,4'b0100,4'b0010,1,4'b1000,3'b000);
    add(0,0,0,2'b00,4'b0000,3'b000,4'b0000,1,4'b0010,4'b0010,0,4'b0010,3'b000);

    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].cond, tbl[i].fw, tbl[i].alu, tbl[i].xin, tbl[i].ctl);
      #4;
      if (tbl[i].chk)
        check_all($sformatf("vec%0d", i), tbl[i].exp_arch, tbl[i].exp_eff, tbl[i].exp_pend,
                  tbl[i].exp_shadow, tbl[i].exp_gate);
      @(posedge clk);
      #1;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [2:0] eg;
      logic       flush_r;
      flush_r = ($urandom_range(0, 9) == 0);
      drive((cyc == 0) || ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            {($urandom_range(0, 7) == 0), flush_r,
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0)});
      #4;
      if (cyc != 0) begin
        eg = (valid_i && cond_ex_i && !flush_i) ? {reg_write_i, mem_write_i, pc_src_i} : 3'b000;
        check_all($sformatf("rnd%0d", cyc), m_arch, model_eff(), (m_pend.size() != 0),
                  m_shadow, eg);
      end
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
